// File: rtl/sweep_seq.sv
// Threshold sweep sequencer: ramps a PWM drive code in steps, lets each step settle for a
// number of PWM periods, and records the first code at which the synchronised comparator trips.
module sweep_seq (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] step_cfg,
    input  logic [3:0] settle_cfg,
    input  logic       cmp_in,
    output logic       pwm_out,
    output logic [7:0] code,
    output logic [7:0] result,
    output logic       busy,
    output logic       done,
    output logic       found
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t     state;
    state_t     state_nx;
    logic [7:0] pcnt;
    logic       cmp_meta;
    logic       cmp_s;
    logic [3:0] wcnt;
    logic [3:0] wcnt_nx;
    logic [7:0] code_nx;
    logic [7:0] result_nx;
    logic       found_nx;
    logic       busy_nx;
    logic       done_nx;
    logic [3:0] step_eff;
    logic [8:0] step_sum;

    // PWM period counter runs in every state so the analog drive never stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt    <= 8'd0;
            pwm_out <= 1'b0;
        end else begin
            pcnt    <= pcnt + 8'd1;
            pwm_out <= (pcnt < code);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmp_meta <= 1'b0;
            cmp_s    <= 1'b0;
        end else begin
            cmp_meta <= cmp_in;
            cmp_s    <= cmp_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            wcnt   <= 4'd0;
            code   <= 8'd0;
            result <= 8'd0;
            found  <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_nx;
            wcnt   <= wcnt_nx;
            code   <= code_nx;
            result <= result_nx;
            found  <= found_nx;
            busy   <= busy_nx;
            done   <= done_nx;
        end
    end

    // Nine-bit sum so a step past 255 is detected instead of wrapping the code
    assign step_eff = (step_cfg == 4'd0) ? 4'd1 : step_cfg;
    assign step_sum = {1'b0, code} + {5'b0, step_eff};

    always_comb begin
        state_nx  = state;
        wcnt_nx   = wcnt;
        code_nx   = code;
        result_nx = result;
        found_nx  = found;
        busy_nx   = busy;
        done_nx   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    code_nx  = 8'd0;
                    wcnt_nx  = 4'd0;
                    busy_nx  = 1'b1;
                    state_nx = SETTLE;
                end
            end
            SETTLE: begin
                // >= rather than == so a mid-step drop of settle_cfg cannot overshoot
                if (pcnt == 8'hFF) begin
                    if (wcnt >= settle_cfg) begin
                        state_nx = SAMPLE;
                    end else begin
                        wcnt_nx = wcnt + 4'd1;
                    end
                end
            end
            SAMPLE: begin
                if (cmp_s) begin
                    result_nx = code;
                    found_nx  = 1'b1;
                    done_nx   = 1'b1;
                    state_nx  = DONE;
                end else if (!step_sum[8]) begin
                    code_nx  = step_sum[7:0];
                    wcnt_nx  = 4'd0;
                    state_nx = SETTLE;
                end else begin
                    result_nx = 8'hFF;
                    found_nx  = 1'b0;
                    done_nx   = 1'b1;
                    state_nx  = DONE;
                end
            end
            DONE: begin
                busy_nx  = 1'b0;
                code_nx  = 8'd0;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

endmodule

// File: doc/sweep_seq.md
SWEEP_SEQ -- requirements
Module: sweep_seq

Interface
REQ-001 SHALL have port clk, input, 1, single clock for all state.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port start, input, 1, sweep request, sampled on rising clk.
REQ-004 SHALL have port step_cfg, input, 4, code increment per step; value 0 SHALL be treated as 1.
REQ-005 SHALL have port settle_cfg, input, 4, settle time of settle_cfg+1 PWM periods per step.
REQ-006 SHALL have port cmp_in, input, 1, asynchronous comparator output from the raw-transistor analog stage.
REQ-007 SHALL have port pwm_out, output, 1, registered gate-drive PWM to the analog stage.
REQ-008 SHALL have port code, output, 8, current drive code.
REQ-009 SHALL have port result, output, 8, threshold code of the last sweep.
REQ-010 SHALL have port busy, output, 1, high while a sweep is in progress.
REQ-011 SHALL have port done, output, 1, one-cycle pulse at sweep end.
REQ-012 SHALL have port found, output, 1, high if the last sweep detected a threshold.

Function
REQ-013 SHALL run an 8-bit free-running PWM counter pcnt, 0..255, wrapping to 0, in every state.
REQ-014 SHALL drive pwm_out on each clk as the registered value of (pcnt < code), giving duty code/256: 0 always low, 255 high 255 of 256 cycles.
REQ-015 SHALL pass cmp_in through a two-flop synchronizer to form cmp_s, with no other use of raw cmp_in.
REQ-016 SHALL implement the states IDLE, SETTLE, SAMPLE and DONE.
REQ-017 SHALL, in IDLE with start=1, load code=0, clear the wrap counter, set busy=1 and enter SETTLE on the next cycle.
REQ-018 SHALL ignore start in every state other than IDLE.
REQ-019 SHALL, in SETTLE, count cycles where pcnt==255 and enter SAMPLE after settle_cfg+1 such wraps, with the first wrap possibly following a partial period.
REQ-020 SHALL, in SAMPLE with cmp_s=1, set result=code and found=1, then enter DONE, all in one cycle.
REQ-021 SHALL, in SAMPLE with cmp_s=0 and code+step<=255 (9-bit compare), set code=code+step, clear the wrap counter and return to SETTLE.
REQ-022 SHALL, in SAMPLE with cmp_s=0 and code+step>255, set result=8'hFF and found=0, then enter DONE, with no wrap of code.
REQ-023 SHALL, in DONE, assert done for exactly one cycle, clear busy, set code=0 and enter IDLE on the next cycle.
REQ-024 SHALL hold result and found from the end of one sweep until the next sweep's DONE.
REQ-025 SHALL sample step_cfg and settle_cfg live each step, so a mid-sweep change takes effect from the next step.
REQ-026 SHALL treat cmp_s=1 already true at code=0 as found with result=0.

Reset
REQ-027 SHALL, on rst_n low at any time including mid-sweep, immediately force state=IDLE, pcnt=0, code=0, pwm_out=0, result=0, busy=0, done=0, found=0, synchronizer flops=0 and wrap counter=0.
REQ-028 SHALL release from reset synchronously on the first clk edge with rst_n high, and SHALL NOT start a sweep without a new start.

Verification
REQ-029 SHALL cover basic threshold: step_cfg=4, settle_cfg=0, cmp_in rises when code>=40 -> done pulse, found=1, result=40, busy low after done.
REQ-030 SHALL cover no threshold: step_cfg=0 (step 1), cmp_in=0 -> code reaches 255, done pulse, found=0, result=8'hFF, code never wraps.
REQ-031 SHALL cover PWM duty: code held at 64 -> pwm_out high exactly 64 of each 256 cycles; code 0 -> pwm_out constantly 0.
REQ-032 SHALL cover settle timing: settle_cfg=3 -> exactly 4 pcnt wraps between consecutive code changes.
REQ-033 SHALL cover reset mid-sweep: rst_n low during SETTLE at code=20 -> all outputs at reset values the same cycle; no done pulse after release.
REQ-034 SHALL cover start while busy: start pulses mid-sweep -> no restart, a single done pulse, result unchanged by the extra pulses.
